// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle MIPS ALU (alu_mc) and its iterative
// multiply/divide unit (mul_div_unit):
//   - 4-bit operation codes
//   - FSM state encoding
//   - byte pattern returned for unrecognised operation codes
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  // Replicated across the result word for any unrecognised op code.
  localparam logic [7:0] DFLT_BYTE = 8'h10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // True for the ops that go through the iterative unit.
  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative unsigned multiply (shift-add, multiplier LSB first) and restoring
// divide (dividend MSB first). One iteration per clock, WIDTH iterations.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset; aborts any operation
//   go      in   load operands and start (only pulsed by the owner when idle)
//   is_div  in   1 = DIVU, 0 = MULTU (sampled with go)
//   a, b    in   operands (sampled with go)
//   hi      out  product high half / remainder, updated on the last iteration
//   lo      out  product low half / quotient, updated on the last iteration
//   fin     out  high during the cycle whose edge performs the last iteration
// ---------------------------------------------------------------------------
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             fin
);

  // Working registers shared by both algorithms:
  //   p_hi_q : partial product high half  / partial remainder
  //   p_lo_q : multiplier (shifting out)  / dividend in, quotient out
  //   opnd_q : multiplicand               / divisor
  logic [WIDTH-1:0] p_hi_q, p_lo_q, opnd_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             running;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    step_hi = p_hi_q;
    step_lo = p_lo_q;

    // Multiply step: add multiplicand if the current multiplier bit is set,
    // then shift the {acc, multiplier} pair right by one.
    mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);

    // Divide step: bring in the next dividend bit, subtract divisor if it
    // fits. The remainder stays below the divisor, so the shifted value needs
    // one extra bit and the difference always fits back into WIDTH bits.
    div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];

    if (div_q) begin
      step_hi = div_rem;
      step_lo = {p_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], p_lo_q[WIDTH-1:1]};
    end
  end

  assign running = (cnt_q != '0);
  assign fin     = (cnt_q == CNT_W'(1));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  // NOTE: every register here, operand and partial registers included, is
  // reset: an aborted operation must leave no trace in hi/lo.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_hi_q <= '0;
      p_lo_q <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (go) begin
      p_hi_q <= '0;
      p_lo_q <= a;
      opnd_q <= b;
      div_q  <= is_div;
      cnt_q  <= CNT_W'(WIDTH);
    end else if (running) begin
      p_hi_q <= step_hi;
      p_lo_q <= step_lo;
      cnt_q  <= cnt_q - CNT_W'(1);
      if (fin) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle integer ALU for the MIPS datapath. Logic/arithmetic ops finish
// in one cycle; MULTU/DIVU run WIDTH iterations in mul_div_unit and write
// HI/LO. All outputs are registered.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   operation request, honoured only while busy = 0
//   op      in   4-bit operation code (see alu_pkg)
//   a, b    in   operands, sampled only at an accepted start
//   busy    out  MULTU/DIVU in flight
//   done    out  one-cycle pulse per accepted start; result/zero/hi/lo valid
//   result  out  registered result, held until the next single-cycle op
//   zero    out  registered, 1 iff result == 0
//   hi, lo  out  HI/LO registers (product halves / remainder, quotient)
// ---------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic             md_go;
  logic             md_is_div;
  logic             md_fin;
  logic [WIDTH-1:0] md_hi, md_lo;

  mul_div_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul_div (
    .clk    (clk),
    .reset  (reset),
    .go     (md_go),
    .is_div (md_is_div),
    .a      (a),
    .b      (b),
    .hi     (md_hi),
    .lo     (md_lo),
    .fin    (md_fin)
  );

  // Single-cycle datapath. MULTU/DIVU also land in the default arm, but the
  // FSM never commits alu_res for them.
  always_comb begin
    alu_res = {(WIDTH/8){DFLT_BYTE}};
    unique case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = (a < b) ? WIDTH'(1) : '0;
      OP_MFHI: alu_res = md_hi;
      OP_MFLO: alu_res = md_lo;
      default: alu_res = {(WIDTH/8){DFLT_BYTE}};
    endcase
  end

  assign md_is_div = (op == OP_DIVU);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    md_go    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multi(op)) begin
            md_go   = 1'b1;
            state_d = RUN;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      RUN: begin
        // start is ignored here; hi/lo are written by the unit on this edge.
        if (md_fin) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign hi     = md_hi;
  assign lo     = md_lo;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Directed-vector bench for alu_mc at WIDTH=32 and WIDTH=8. Inputs change on
// the falling edge; outputs are compared on the falling edge too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_mc;

  localparam logic [3:0] AND_OP   = 4'b0000;
  localparam logic [3:0] OR_OP    = 4'b0001;
  localparam logic [3:0] ADD_OP   = 4'b0010;
  localparam logic [3:0] SUB_OP   = 4'b0110;
  localparam logic [3:0] SLT_OP   = 4'b0111;
  localparam logic [3:0] MULTU_OP = 4'b1000;
  localparam logic [3:0] DIVU_OP  = 4'b1001;
  localparam logic [3:0] MFHI_OP  = 4'b1010;
  localparam logic [3:0] MFLO_OP  = 4'b1011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel8;
  logic [3:0]  op;
  logic [31:0] a, b;

  logic        busy32, done32, zero32;
  logic [31:0] result32, hi32, lo32;
  logic        busy8, done8, zero8;
  logic [7:0]  result8, hi8, lo8;

  logic        busy_s, done_s, zero_s;
  logic [31:0] result_s, hi_s, lo_s;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) u_dut32 (
    .clk    (clk),
    .reset  (reset),
    .start  (start & ~sel8),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy32),
    .done   (done32),
    .result (result32),
    .zero   (zero32),
    .hi     (hi32),
    .lo     (lo32)
  );

  alu_mc #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .start  (start & sel8),
    .op     (op),
    .a      (a[7:0]),
    .b      (b[7:0]),
    .busy   (busy8),
    .done   (done8),
    .result (result8),
    .zero   (zero8),
    .hi     (hi8),
    .lo     (lo8)
  );

  assign busy_s   = sel8 ? busy8 : busy32;
  assign done_s   = sel8 ? done8 : done32;
  assign zero_s   = sel8 ? zero8 : zero32;
  assign result_s = sel8 ? {24'h0, result8} : result32;
  assign hi_s     = sel8 ? {24'h0, hi8} : hi32;
  assign lo_s     = sel8 ? {24'h0, lo8} : lo32;

  // Count done pulses from both instances, settled after each rising edge.
  always @(posedge clk) begin
    #1;
    if (done32 || done8) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the rising
  // edge that sampled start.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges with busy high, starting at the current one.
  task automatic wait_done(output int n);
    n = 0;
    while (busy_s && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_single(input string tag, input logic [31:0] exp_res, input logic exp_zero);
    check({tag, "_done"}, {31'b0, done_s}, 32'd1);
    check({tag, "_res"}, result_s, exp_res);
    check({tag, "_zero"}, {31'b0, zero_s}, {31'b0, exp_zero});
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc0;

    reset = 1'b1;
    start = 1'b0;
    sel8  = 1'b0;
    op    = 4'h0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", {31'b0, busy_s}, 32'd0);
    check("rst_done", {31'b0, done_s}, 32'd0);
    check("rst_res", result_s, 32'd0);
    check("rst_zero", {31'b0, zero_s}, 32'd0);
    check("rst_hi", hi_s, 32'd0);
    check("rst_lo", lo_s, 32'd0);

    // Back-to-back single-cycle ops: one result per cycle.
    issue(ADD_OP, 32'hFFFF_FFFF, 32'd1);       check_single("add_wrap", 32'h0000_0000, 1'b1);
    issue(SUB_OP, 32'd5, 32'd7);               check_single("sub_neg", 32'hFFFF_FFFE, 1'b0);
    issue(AND_OP, 32'hF0F0_F0F0, 32'h0FF0_0FF0); check_single("and", 32'h00F0_00F0, 1'b0);
    issue(OR_OP, 32'hF0F0_F0F0, 32'h0FF0_0FF0);  check_single("or", 32'hFFF0_FFF0, 1'b0);
    issue(SLT_OP, 32'hF0F0_F0F0, 32'h0FF0_0FF0); check_single("slt_0", 32'h0000_0000, 1'b1);
    issue(SLT_OP, 32'h0FF0_0FF0, 32'hF0F0_F0F0); check_single("slt_1", 32'h0000_0001, 1'b0);
    issue(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0); check_single("unk_op", 32'h1010_1010, 1'b0);
    @(negedge clk);
    check("done_drop", {31'b0, done_s}, 32'd0);

    // MULTU: busy for WIDTH cycles, done one cycle later.
    issue(MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("mul_busy_cyc", 32'(n), 32'd32);
    check("mul_done", {31'b0, done_s}, 32'd1);
    check("mul_hi", hi_s, 32'hFFFF_FFFE);
    check("mul_lo", lo_s, 32'h0000_0001);
    check("mul_res_kept", result_s, 32'h1010_1010);
    // Issued on the done cycle: must be accepted and see the new HI/LO.
    issue(MFHI_OP, 32'd0, 32'd0); check_single("mfhi", 32'hFFFF_FFFE, 1'b0);
    issue(MFLO_OP, 32'd0, 32'd0); check_single("mflo", 32'h0000_0001, 1'b0);

    issue(DIVU_OP, 32'd100, 32'd7);
    wait_done(n);
    check("div_busy_cyc", 32'(n), 32'd32);
    check("div_lo", lo_s, 32'd14);
    check("div_hi", hi_s, 32'd2);

    issue(DIVU_OP, 32'd1234, 32'd0);
    wait_done(n);
    check("div0_busy_cyc", 32'(n), 32'd32);
    check("div0_done", {31'b0, done_s}, 32'd1);
    check("div0_lo", lo_s, 32'hFFFF_FFFF);
    check("div0_hi", hi_s, 32'd1234);
    @(negedge clk);

    // start during RUN is dropped; operand changes do not disturb the op.
    dc0 = done_cnt;
    issue(MULTU_OP, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    issue(ADD_OP, 32'd1, 32'd1);
    wait_done(n);
    check("ign_busy_cyc", 32'(n), 32'd28);
    check("ign_hi", hi_s, 32'd0);
    check("ign_lo", lo_s, 32'd42);
    check("ign_res", result_s, 32'h0000_0001);
    @(negedge clk);
    check("ign_done_cnt", 32'(done_cnt - dc0), 32'd1);

    // Reset at iteration 10 aborts with no done pulse.
    issue(DIVU_OP, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    dc0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy_s}, 32'd0);
    check("abort_done", {31'b0, done_s}, 32'd0);
    check("abort_res", result_s, 32'd0);
    check("abort_hi", hi_s, 32'd0);
    check("abort_lo", lo_s, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

    // WIDTH = 8 instance.
    sel8 = 1'b1;
    issue(MULTU_OP, 32'hFF, 32'hFF);
    wait_done(n);
    check("w8_mul_busy_cyc", 32'(n), 32'd8);
    check("w8_mul_done", {31'b0, done_s}, 32'd1);
    check("w8_mul_hi", hi_s, 32'hFE);
    check("w8_mul_lo", lo_s, 32'h01);

    issue(DIVU_OP, 32'd100, 32'd7);
    wait_done(n);
    check("w8_div_busy_cyc", 32'(n), 32'd8);
    check("w8_div_lo", lo_s, 32'd14);
    check("w8_div_hi", hi_s, 32'd2);

    issue(DIVU_OP, 32'hD2, 32'd0);
    wait_done(n);
    check("w8_div0_busy_cyc", 32'(n), 32'd8);
    check("w8_div0_lo", lo_s, 32'hFF);
    check("w8_div0_hi", hi_s, 32'hD2);
    issue(MFHI_OP, 32'd0, 32'd0); check_single("w8_mfhi", 32'hD2, 1'b0);
    issue(4'b1111, 32'd0, 32'd0); check_single("w8_unk", 32'h10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
